// File: rtl/display_pkg.sv
// Shared seven-segment constants and BCD decode, active-high {g,f,e,d,c,b,a}.
// Pure combinational helpers: no latency, no flow control.
package display_pkg;
   localparam int SEG_W = 7;
   localparam int BCD_W = 4;

   localparam logic [SEG_W-1:0] SEG_PATTERN [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };
   localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

   // Codes above 9 decode to a dark digit rather than garbage.
   function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] d);
      logic [SEG_W-1:0] p;
      p = SEG_OFF;
      for (int i = 0; i < 10; i++)
         if (d == BCD_W'(i)) p = SEG_PATTERN[i];
      return p;
   endfunction
endpackage

// File: rtl/tick_divider.sv
// Free-running divide-by-DIV counter with a one-cycle tick on its last count.
// Tick is combinational from the count register; no backpressure.
module tick_divider #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);
   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + W'(1);
   end

   assign tick = (cnt == LAST);
endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter driving a multiplexed 7-seg display; value/wrap one cycle after tick,
// seg/an one cycle after scan index; no backpressure. Optional LEADING_ZERO_BLANK_EN blanks leading zeros.
module bcd_scan_counter
   import display_pkg::*;
#(
   parameter int CLK_HZ         = 100_000_000,
   parameter int TICK_HZ        = 1,
   parameter int SCAN_HZ        = 1000,
   parameter int NUM_DIGITS     = 4,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic                        up,
   input  logic                        load,
   input  logic [4*NUM_DIGITS-1:0]     load_val,
   output logic [4*NUM_DIGITS-1:0]     value,
   output logic                        wrap,
   output logic [6:0]                  seg,
   output logic [NUM_DIGITS-1:0]       an
);
   localparam int TDIV = CLK_HZ / TICK_HZ;
   localparam int SDIV = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
   localparam int VW   = BCD_W * NUM_DIGITS;
   localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic ACT_LOW = (SEG_ACTIVE_LOW != 0);

   logic count_tick, scan_tick;

   tick_divider #(.DIV(TDIV)) u_count_div (.clk(clk), .rst_n(rst_n), .tick(count_tick));
   tick_divider #(.DIV(SDIV)) u_scan_div  (.clk(clk), .rst_n(rst_n), .tick(scan_tick));

   logic [VW-1:0] inc_val, dec_val, clamp_val;
   logic          inc_wrap, dec_wrap;

   // inc_wrap/dec_wrap double as the ripple carry/borrow; surviving the last digit means all-9s/all-0s.
   always_comb begin
      inc_val   = value;
      dec_val   = value;
      clamp_val = load_val;
      inc_wrap  = 1'b1;
      dec_wrap  = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (inc_wrap) begin
            if (value[i*BCD_W +: BCD_W] >= 4'd9)
               inc_val[i*BCD_W +: BCD_W] = 4'd0;
            else begin
               inc_val[i*BCD_W +: BCD_W] = value[i*BCD_W +: BCD_W] + 4'd1;
               inc_wrap = 1'b0;
            end
         end
         if (dec_wrap) begin
            if (value[i*BCD_W +: BCD_W] == 4'd0)
               dec_val[i*BCD_W +: BCD_W] = 4'd9;
            else begin
               dec_val[i*BCD_W +: BCD_W] = value[i*BCD_W +: BCD_W] - 4'd1;
               dec_wrap = 1'b0;
            end
         end
         if (load_val[i*BCD_W +: BCD_W] > 4'd9)
            clamp_val[i*BCD_W +: BCD_W] = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
         wrap  <= 1'b0;
      end else if (load) begin
         value <= clamp_val;
         wrap  <= 1'b0;
      end else if (count_tick && en) begin
         value <= up ? inc_val : dec_val;
         wrap  <= up ? inc_wrap : dec_wrap;
      end else begin
         wrap  <= 1'b0;
      end
   end

   logic [NUM_DIGITS-1:0] blank;
`ifdef LEADING_ZERO_BLANK_EN
   logic nz_above;
   always_comb begin
      blank    = '0;
      nz_above = 1'b0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         nz_above = nz_above | (value[i*BCD_W +: BCD_W] != 4'd0);
         blank[i] = !nz_above;
      end
   end
`else
   assign blank = '0;
`endif

   logic [IW-1:0]         idx;
   logic [BCD_W-1:0]      cur_digit;
   logic [SEG_W-1:0]      cur_seg;
   logic [NUM_DIGITS-1:0] cur_an;

   always_comb begin
      cur_digit   = value[int'(idx)*BCD_W +: BCD_W];
      cur_seg     = blank[idx] ? SEG_OFF : bcd_to_seg(cur_digit);
      cur_an      = '0;
      cur_an[idx] = 1'b1;
   end

   // seg and an come from the same idx in the same edge, so a digit never shows its neighbour's pattern.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
         seg <= ACT_LOW ? ~SEG_OFF : SEG_OFF;
         an  <= ACT_LOW ? '1 : '0;
      end else begin
         if (scan_tick)
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
         seg <= ACT_LOW ? ~cur_seg : cur_seg;
         an  <= ACT_LOW ? ~cur_an : cur_an;
      end
   end
endmodule
